// File: rtl/regfile_write_arbiter.sv
// Two-requester arbiter for the register file write port.
// Registered round-robin grant with a per-owner burst cap under contention.
module regfile_write_arbiter #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              Clk,
  input  logic              RESET,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic              RegWrEn,
  output logic [ADDR_W-1:0] RegWrAddr,
  output logic [DATA_W-1:0] RegWrData,
  output logic              Busy
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StOwn0 = 2'd1;
  localparam logic [1:0] StOwn1 = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            last_q, last_d;

  logic own_id, own_req, oth_req, own_ack, burst_done;
  logic [1:0] oth_state;

  always_comb begin
    gnt0      = (state_q == StOwn0);
    gnt1      = (state_q == StOwn1);
    // RESET gates the acks so no write can land on a reset edge, even mid-burst.
    ack0      = gnt0 & req0 & (cnt_q < CntMax) & RESET;
    ack1      = gnt1 & req1 & (cnt_q < CntMax) & RESET;
    RegWrEn   = ack0 | ack1;
    RegWrAddr = ack0 ? addr0 : (ack1 ? addr1 : '0);
    RegWrData = ack0 ? data0 : (ack1 ? data1 : '0);
    Busy      = (state_q != StIdle);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    own_id     = (state_q == StOwn1);
    own_req    = own_id ? req1 : req0;
    oth_req    = own_id ? req0 : req1;
    own_ack    = ack0 | ack1;
    oth_state  = own_id ? StOwn0 : StOwn1;
    burst_done = ((cnt_q + CntW'(1)) == CntMax);

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        // last_q == 1 means req1 was served last, so req0 wins a tie.
        if (req0 && (!req1 || last_q)) begin
          state_d = StOwn0;
        end else if (req1) begin
          state_d = StOwn1;
        end
      end
      StOwn0, StOwn1: begin
        if (!own_req) begin
          state_d = oth_req ? oth_state : StIdle;
          cnt_d   = '0;
          last_d  = own_id;
        end else if (own_ack) begin
          if (burst_done) begin
            // A lone requester keeps the port; the count just restarts.
            cnt_d = '0;
            if (oth_req) begin
              state_d = oth_state;
              last_d  = own_id;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!RESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

endmodule
